// File: rtl/fetch_queue_pkg.sv
// Shared widths for the fetch/decode boundary; FQ_DEPTH is the top-level override for the queue size.
package fetch_queue_pkg;

    localparam int XLEN     = 32;
    localparam int FQ_DEPTH = 4;

endpackage

// File: rtl/fetch_queue.sv
// In-order instruction buffer between fetch and decode; a new entry reaches the head one cycle after it is written.
// enq_ready is simply !full from registered pointers; flush and reset drop the contents by clearing the pointers.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enq_valid,
    input  logic [XLEN-1:0]           enq_inst,
    input  logic [XLEN-1:0]           enq_pc,
    output logic                      enq_ready,
    input  logic                      flush,
    output logic                      deq_valid,
    output logic [XLEN-1:0]           deq_inst,
    output logic [XLEN-1:0]           deq_pc,
    input  logic                      deq_ready,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [XLEN-1:0] mem_inst [DEPTH];
    logic [XLEN-1:0] mem_pc   [DEPTH];

    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          empty;
    logic          full;
    logic          enq_fire;
    logic          deq_fire;

    // The extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);

    assign enq_ready = !full;
    assign deq_valid = !empty;

    assign enq_fire = enq_valid && enq_ready && !flush;
    assign deq_fire = deq_valid && deq_ready && !flush;

    assign deq_inst = mem_inst[rptr[AW-1:0]];
    assign deq_pc   = mem_pc[rptr[AW-1:0]];

    assign count = wptr - rptr;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (enq_fire) begin
                wptr <= wptr + PW'(1);
            end
            if (deq_fire) begin
                rptr <= rptr + PW'(1);
            end
        end
    end

    // Storage is never cleared; stale slots are unreachable once the pointers reset.
    always_ff @(posedge clk) begin
        if (enq_fire && !rst) begin
            mem_inst[wptr[AW-1:0]] <= enq_inst;
            mem_pc[wptr[AW-1:0]]   <= enq_pc;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed and random checks of fetch_queue against a queue-based reference model.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            enq_valid;
    logic [XLEN-1:0] enq_inst;
    logic [XLEN-1:0] enq_pc;
    logic            enq_ready;
    logic            flush;
    logic            deq_valid;
    logic [XLEN-1:0] deq_inst;
    logic [XLEN-1:0] deq_pc;
    logic            deq_ready;
    logic [2:0]      count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] model_q [$];

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .enq_valid (enq_valid),
        .enq_inst  (enq_inst),
        .enq_pc    (enq_pc),
        .enq_ready (enq_ready),
        .flush     (flush),
        .deq_valid (deq_valid),
        .deq_inst  (deq_inst),
        .deq_pc    (deq_pc),
        .deq_ready (deq_ready),
        .count     (count)
    );

    always #5 clk = ~clk;

    function automatic logic [XLEN-1:0] inst_of(input logic [XLEN-1:0] pc);
        return pc ^ 32'hA5C3_0013;
    endfunction

    // Reference: FIFO semantics with flush/reset priority and full-blocks-enqueue.
    task automatic tick();
        bit do_deq;
        bit do_enq;
        if (rst || flush) begin
            model_q.delete();
        end else begin
            do_deq = deq_ready && (model_q.size() > 0);
            do_enq = enq_valid && (model_q.size() < DEPTH);
            if (do_deq) void'(model_q.pop_front());
            if (do_enq) model_q.push_back({enq_pc, enq_inst});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst = 1'b0; flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
        enq_pc = '0; enq_inst = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_checks++;
        if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
        n_checks++;
        if (deq_valid !== 1'b0) begin n_fail++; $display("FAIL reset_deq_valid: got %b want 0", deq_valid); end
        n_checks++;
        if (enq_ready !== 1'b1) begin n_fail++; $display("FAIL reset_enq_ready: got %b want 1", enq_ready); end
    endtask

    task automatic test_order();
        logic [XLEN-1:0] insts [3];
        insts[0] = 32'h0000_0013; insts[1] = 32'h0010_0093; insts[2] = 32'h0020_0113;
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            enq_valid = 1'b1; enq_pc = XLEN'(4 * i); enq_inst = insts[i];
            tick();
        end
        enq_valid = 1'b0;
        n_checks++;
        if (count !== 3'd3) begin n_fail++; $display("FAIL order_count: got %0d want 3", count); end
        n_checks++;
        if (deq_pc !== 32'h0) begin n_fail++; $display("FAIL order_head_pc: got %h want 0", deq_pc); end
        deq_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (deq_valid !== 1'b1 || deq_pc !== XLEN'(4 * i) || deq_inst !== insts[i]) begin
                n_fail++;
                $display("FAIL order_out%0d: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h",
                         i, deq_valid, deq_pc, deq_inst, 4 * i, insts[i]);
            end
            tick();
        end
        n_checks++;
        if (deq_valid !== 1'b0) begin n_fail++; $display("FAIL order_drained: got %b want 0", deq_valid); end
        idle_inputs();
    endtask

    task automatic test_full();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            enq_valid = 1'b1; enq_pc = 32'h40 + XLEN'(4 * i); enq_inst = inst_of(enq_pc);
            tick();
        end
        n_checks++;
        if (enq_ready !== 1'b0 || count !== 3'd4) begin
            n_fail++; $display("FAIL full_state: got rdy=%b cnt=%0d want rdy=0 cnt=4", enq_ready, count);
        end
        enq_pc = 32'h99; enq_inst = inst_of(32'h99);
        tick();
        n_checks++;
        if (count !== 3'd4 || deq_pc !== 32'h40) begin
            n_fail++; $display("FAIL full_ignore: got cnt=%0d pc=%h want cnt=4 pc=40", count, deq_pc);
        end
        // Dequeue while full: the held enqueue must not slip in this cycle.
        deq_ready = 1'b1;
        tick();
        enq_valid = 1'b0;
        n_checks++;
        if (enq_ready !== 1'b1 || count !== 3'd3) begin
            n_fail++; $display("FAIL full_release: got rdy=%b cnt=%0d want rdy=1 cnt=3", enq_ready, count);
        end
        for (int i = 1; i < 4; i++) begin
            n_checks++;
            if (deq_valid !== 1'b1 || deq_pc !== 32'h40 + XLEN'(4 * i)) begin
                n_fail++; $display("FAIL full_drain%0d: got v=%b pc=%h want v=1 pc=%h", i, deq_valid, deq_pc, 32'h40 + 4 * i);
            end
            tick();
        end
        n_checks++;
        if (deq_valid !== 1'b0) begin n_fail++; $display("FAIL full_extra: got v=%b pc=%h want v=0", deq_valid, deq_pc); end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        enq_valid = 1'b1; enq_pc = 32'h100; enq_inst = inst_of(32'h100);
        tick();
        deq_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            if (i < 16) begin
                enq_pc = 32'h100 + XLEN'(4 * i); enq_inst = inst_of(enq_pc);
            end else begin
                enq_valid = 1'b0;
            end
            n_checks++;
            if (count !== 3'd1 || deq_valid !== 1'b1 || deq_pc !== 32'h100 + XLEN'(4 * (i - 1))
                || deq_inst !== inst_of(32'h100 + XLEN'(4 * (i - 1)))) begin
                n_fail++;
                $display("FAIL b2b_%0d: got cnt=%0d v=%b pc=%h inst=%h want cnt=1 v=1 pc=%h",
                         i, count, deq_valid, deq_pc, deq_inst, 32'h100 + 4 * (i - 1));
            end
            tick();
        end
        n_checks++;
        if (deq_valid !== 1'b0 || count !== 3'd0) begin
            n_fail++; $display("FAIL b2b_end: got v=%b cnt=%0d want v=0 cnt=0", deq_valid, count);
        end
        idle_inputs();
    endtask

    task automatic test_flush();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            enq_valid = 1'b1; enq_pc = 32'h500 + XLEN'(4 * i); enq_inst = inst_of(enq_pc);
            tick();
        end
        flush = 1'b1; deq_ready = 1'b1; enq_pc = 32'h200; enq_inst = inst_of(32'h200);
        tick();
        flush = 1'b0; deq_ready = 1'b0;
        n_checks++;
        if (count !== 3'd0 || deq_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_clear: got cnt=%0d v=%b want cnt=0 v=0", count, deq_valid);
        end
        enq_pc = 32'h300; enq_inst = inst_of(32'h300);
        tick();
        enq_valid = 1'b0;
        n_checks++;
        if (deq_valid !== 1'b1 || deq_pc !== 32'h300 || count !== 3'd1) begin
            n_fail++; $display("FAIL flush_next: got v=%b pc=%h cnt=%0d want v=1 pc=300 cnt=1", deq_valid, deq_pc, count);
        end
        deq_ready = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic test_no_bypass();
        idle_inputs();
        enq_valid = 1'b1; enq_pc = 32'h400; enq_inst = inst_of(32'h400); deq_ready = 1'b1;
        #1;
        n_checks++;
        if (deq_valid !== 1'b0) begin n_fail++; $display("FAIL bypass_same_cycle: got v=%b want 0", deq_valid); end
        tick();
        enq_valid = 1'b0;
        n_checks++;
        if (deq_valid !== 1'b1 || deq_pc !== 32'h400) begin
            n_fail++; $display("FAIL bypass_next: got v=%b pc=%h want v=1 pc=400", deq_valid, deq_pc);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_rst_mid();
        idle_inputs();
        for (int i = 0; i < 2; i++) begin
            enq_valid = 1'b1; enq_pc = 32'h600 + XLEN'(4 * i); enq_inst = inst_of(enq_pc);
            tick();
        end
        rst = 1'b1; enq_pc = 32'h700; enq_inst = inst_of(32'h700); deq_ready = 1'b1;
        tick();
        rst = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
        n_checks++;
        if (count !== 3'd0 || deq_valid !== 1'b0 || enq_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid: got cnt=%0d v=%b rdy=%b want cnt=0 v=0 rdy=1", count, deq_valid, enq_ready);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        logic [63:0] head;
        idle_inputs();
        model_q.delete();
        for (int c = 0; c < 600; c++) begin
            enq_valid = 1'($urandom_range(0, 3) != 0);
            deq_ready = 1'($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 29) == 0);
            rst       = ($urandom_range(0, 99) == 0);
            enq_pc    = $urandom;
            enq_inst  = $urandom;
            n_checks++;
            if (count !== 3'(model_q.size()) || deq_valid !== (model_q.size() != 0)
                || enq_ready !== (model_q.size() < DEPTH)) begin
                n_fail++;
                $display("FAIL rand_state@%0d: got cnt=%0d v=%b rdy=%b want cnt=%0d", c, count, deq_valid, enq_ready, model_q.size());
            end
            if (model_q.size() != 0) begin
                head = model_q[0];
                n_checks++;
                if ({deq_pc, deq_inst} !== head) begin
                    n_fail++;
                    $display("FAIL rand_head@%0d: got pc=%h inst=%h want pc=%h inst=%h", c, deq_pc, deq_inst, head[63:32], head[31:0]);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_order();
        test_full();
        test_back_to_back();
        test_flush();
        test_no_bypass();
        test_rst_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
